// File: rtl/spi_target_rx_if.sv
// spi_target_rx_if: bundles the SPI pins and the register-file port of
// spi_target_rx.
//   slave  modport : the SPI target (spi_target_rx) side
//   master modport : the SPI host / register-file side (bench or parent)
// Signals:
//   spi_sclk, spi_mosi, spi_cs_n : SPI pins from the host
//   spi_miso                     : SPI read data to the host
//   wr_en, wr_addr, wr_data      : register-file write strobe, address, data
//   rd_req, rd_addr, rd_data     : register-file read request, address, data
//   frame_err                    : one-cycle pulse on a malformed frame
//   busy                         : frame in progress
interface spi_target_rx_if #(
  parameter int DATA_W = 32
);
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic              spi_miso;
  logic              wr_en;
  logic [6:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [6:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n, rd_data,
    output spi_miso, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
  );

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n, rd_data,
    input  spi_miso, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
  );
endinterface

// File: rtl/spi_target_rx.sv
// spi_target_rx: SPI mode-0 target front end. Oversamples sclk/mosi/cs_n on
// clk, deserialises 8-bit address + DATA_W-bit data frames (MSB first),
// issues one-cycle register writes and, for read frames, shifts register
// data out on spi_miso.
// Ports:
//   clk    : system clock (sclk must be <= clk/8)
//   rst_n  : asynchronous active-low reset
//   bus    : spi_target_rx_if.slave (SPI pins + register-file port)
// Build option:
//   SPI_READBACK_EN : when defined, address bit 7 = 1 frames are served as
//                     reads; when undefined they are received and dropped,
//                     rd_req and spi_miso stay 0.
module spi_target_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_target_rx_if.slave  bus
);
  localparam int FRAME_BITS = 8 + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME     = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  // Input synchronisers plus one extra copy for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_dly, cs_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_dly  <= 1'b0;
      cs_dly    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
      cs_dly    <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, mosi_s, cs_s;
  logic sclk_en, sclk_rise, cs_fall, cs_rise;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  // sclk is still honoured on the cycle cs_n rises, so a final bit that
  // lands together with cs_n release is counted.
  assign sclk_en   = ~(cs_s & cs_dly);
  assign sclk_rise = sclk_en & sclk_s & ~sclk_dly;
  assign cs_fall   = ~cs_s & cs_dly;
  assign cs_rise   = cs_s & ~cs_dly;

  // Frame FSM
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [DATA_W-1:0] rx_shift, rx_word;
  logic              shift_en, addr_done, data_done, frame_bad;
  logic              is_read;
  logic [6:0]        addr_lo;

  assign rx_word = {rx_shift[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_en  = 1'b0;
    addr_done = 1'b0;
    data_done = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_nxt = ADDR;
      ADDR: if (sclk_rise) begin
        shift_en = 1'b1;
        cnt_nxt  = bit_cnt + CNT_ONE;
        if (bit_cnt == CNT_ADDR_LAST) begin
          addr_done = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: if (sclk_rise) begin
        shift_en = 1'b1;
        cnt_nxt  = bit_cnt + CNT_ONE;
        if (bit_cnt == CNT_DATA_LAST) begin
          data_done = 1'b1;
          state_nxt = DONE;
        end
      end
      // Only tracks over-length; the count saturates at FRAME_BITS+1.
      DONE: if (sclk_rise && bit_cnt == CNT_FRAME) cnt_nxt = bit_cnt + CNT_ONE;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) state_nxt = IDLE;
  end

  assign frame_bad = cs_rise && (cnt_nxt != '0) && (cnt_nxt != CNT_FRAME);

  // Receive datapath and write port
  logic              busy_r, frame_err_r, wr_en_r;
  logic [6:0]        wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      is_read     <= 1'b0;
      addr_lo     <= '0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
    end else begin
      wr_en_r     <= 1'b0;
      frame_err_r <= frame_bad;
      if (state == IDLE && cs_fall) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        is_read  <= 1'b0;
        busy_r   <= 1'b1;
      end else begin
        bit_cnt <= cnt_nxt;
        if (shift_en) rx_shift <= rx_word;
      end
      if (addr_done) begin
        is_read <= rx_word[7];
        addr_lo <= rx_word[6:0];
      end
      if (data_done && !is_read) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= addr_lo;
        wr_data_r <= rx_word;
      end
      if (cs_rise) begin
        bit_cnt <= '0;
        busy_r  <= 1'b0;
      end
    end
  end

  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

`ifdef SPI_READBACK_EN
  // Read request, then load/shift of the transmit register
  logic              sclk_fall;
  logic              rd_req_r, ld_tx, miso_r;
  logic [6:0]        rd_addr_r;
  logic [DATA_W-1:0] tx_shift;

  assign sclk_fall = sclk_en & ~sclk_s & sclk_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_r  <= 1'b0;
      rd_addr_r <= '0;
      ld_tx     <= 1'b0;
      tx_shift  <= '0;
      miso_r    <= 1'b0;
    end else begin
      rd_req_r <= addr_done & rx_word[7] & ~cs_rise;
      if (addr_done && rx_word[7]) rd_addr_r <= rx_word[6:0];
      ld_tx <= rd_req_r;
      if (cs_rise) begin
        ld_tx  <= 1'b0;
        miso_r <= 1'b0;
      end else if (ld_tx && state == DATA) begin
        tx_shift <= bus.rd_data;
        miso_r   <= bus.rd_data[DATA_W-1];
      // The falling edge right after the address byte precedes the first
      // data-phase sample, so the loaded MSB must not be shifted away there.
      end else if (sclk_fall && state == DATA && is_read && bit_cnt > CNT_ADDR_LAST + CNT_ONE) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        miso_r   <= tx_shift[DATA_W-2];
      end
    end
  end

  assign bus.rd_req   = rd_req_r;
  assign bus.rd_addr  = rd_addr_r;
  assign bus.spi_miso = miso_r;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^bus.rd_data;
  assign bus.rd_req     = 1'b0;
  assign bus.rd_addr    = '0;
  assign bus.spi_miso   = 1'b0;
`endif

endmodule
